halfword_assembler: RTL and testbench

Byte-to-halfword assembler feeding the 16-bit sign/zero `extend` stage. Accepts a stream of 8-bit bytes over a valid/ready handshake and pairs them into a 16-bit halfword. Captures the extension mode (`sext`) with the first byte and presents `a[15:0]` plus `sext` to the extender under a registered valid/ready output. Supports abandoned-pair timeout, synchronous flush, and an emitted-halfword counter.

---
 rtl/halfword_asm_pkg.sv | 23 ++
 rtl/hw_timeout_ctr.sv | 42 ++++
 rtl/halfword_assembler.sv | 152 +++++++++++++++
 tb/tb_halfword_assembler.sv | 259 +++++++++++++++++++++++++
 4 files changed

// File: rtl/halfword_asm_pkg.sv
// Shared types and constants for the byte-to-halfword assembler.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package halfword_asm_pkg;

   localparam int BYTE_W          = 8;
   localparam int HW_W            = 16;
   localparam int TIMEOUT_DEFAULT = 16;

   typedef enum logic [1:0] {
      ST_EMPTY = 2'b00,
      ST_HALF  = 2'b01,
      ST_FULL  = 2'b10
   } state_e;

   // Orders the two bytes of a pair into a halfword; be=1 puts the first byte on top.
   function automatic logic [HW_W-1:0] pack_hw(input logic [BYTE_W-1:0] first,
                                               input logic [BYTE_W-1:0] second,
                                               input logic              be);
      return be ? {first, second} : {second, first};
   endfunction

endpackage

// File: rtl/hw_timeout_ctr.sv
// Idle-cycle counter that saturates at MAX and flags expiry; MAX=0 never expires.
// Latency: expired_o is registered, high the cycle after the MAX-th enabled cycle.
// Backpressure: none; clr_i wins over en_i.
module hw_timeout_ctr #(
   parameter int MAX = 16
) (
   input  logic clk,
   input  logic rst,
   input  logic clr_i,
   input  logic en_i,
   output logic expired_o
);

   generate
      if (MAX == 0) begin : g_disabled
         assign expired_o = 1'b0;
      end else begin : g_count
         localparam int CW = $clog2(MAX + 1);

         logic [CW-1:0] cnt_q, cnt_d;

         // Next count: clear, or step while enabled and not yet saturated.
         always_comb begin
            cnt_d = cnt_q;
            if (clr_i) begin
               cnt_d = '0;
            end else if (en_i && (cnt_q != CW'(MAX))) begin
               cnt_d = cnt_q + CW'(1);
            end
         end

         // Count register.
         always_ff @(posedge clk or posedge rst) begin
            if (rst) cnt_q <= '0;
            else     cnt_q <= cnt_d;
         end

         assign expired_o = (cnt_q == CW'(MAX));
      end
   endgenerate

endmodule

// File: rtl/halfword_assembler.sv
// Pairs 8-bit bytes into a 16-bit halfword (+ sext) for the extend stage; optional ASSEMBLER_BE_EN adds big_endian.
// Latency: out_valid rises on the edge accepting the second byte; one halfword per 2 cycles sustained.
// Backpressure: in_ready drops while a halfword is held and out_ready is low, and during flush/reset.
module halfword_assembler
   import halfword_asm_pkg::*;
#(
   parameter int TIMEOUT = TIMEOUT_DEFAULT
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [BYTE_W-1:0] in_data,
   input  logic              in_sext,
`ifdef ASSEMBLER_BE_EN
   input  logic              big_endian,
`endif
   input  logic              flush,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [HW_W-1:0]   a,
   output logic              sext,
   output logic              timeout_err,
   output logic [15:0]       hw_count
);

   state_e            state_q, state_d;
   logic [BYTE_W-1:0] first_q, first_d;
   logic              hsext_q, hsext_d;
   logic              hbe_q, hbe_d;
   logic [HW_W-1:0]   a_q, a_d;
   logic              sext_q, sext_d;
   logic              out_valid_q, out_valid_d;
   logic              terr_q, terr_d;
   logic [15:0]       cnt_q, cnt_d;

   logic be_in;
   logic in_hs, out_hs;
   logic expired;

`ifdef ASSEMBLER_BE_EN
   assign be_in = big_endian;
`else
   assign be_in = 1'b0;
`endif

   // A held halfword blocks new bytes unless it leaves this same cycle.
   assign in_ready = !rst && !flush && ((state_q != ST_FULL) || out_ready);
   assign in_hs    = in_valid && in_ready;
   assign out_hs   = out_valid_q && out_ready && !flush;

   // Counts idle HALF cycles; any accepted byte or leaving HALF restarts it.
   hw_timeout_ctr #(
      .MAX (TIMEOUT)
   ) u_timeout (
      .clk       (clk),
      .rst       (rst),
      .clr_i     ((state_q != ST_HALF) || in_hs),
      .en_i      ((state_q == ST_HALF) && !in_hs),
      .expired_o (expired)
   );

   // FSM and datapath next-state; flush overrides everything.
   always_comb begin
      state_d     = state_q;
      first_d     = first_q;
      hsext_d     = hsext_q;
      hbe_d       = hbe_q;
      a_d         = a_q;
      sext_d      = sext_q;
      out_valid_d = out_valid_q;
      terr_d      = 1'b0;
      cnt_d       = cnt_q;
      if (flush) begin
         state_d     = ST_EMPTY;
         out_valid_d = 1'b0;
      end else begin
         case (state_q)
            ST_EMPTY: begin
               if (in_hs) begin
                  state_d = ST_HALF;
                  first_d = in_data;
                  hsext_d = in_sext;
                  hbe_d   = be_in;
               end
            end
            ST_HALF: begin
               // A byte arriving in the expiry cycle still completes the pair.
               if (in_hs) begin
                  state_d     = ST_FULL;
                  a_d         = pack_hw(first_q, in_data, hbe_q);
                  sext_d      = hsext_q;
                  out_valid_d = 1'b1;
               end else if (expired) begin
                  state_d = ST_EMPTY;
                  terr_d  = 1'b1;
               end
            end
            ST_FULL: begin
               if (out_hs) begin
                  cnt_d       = cnt_q + 16'd1;
                  out_valid_d = 1'b0;
                  if (in_hs) begin
                     state_d = ST_HALF;
                     first_d = in_data;
                     hsext_d = in_sext;
                     hbe_d   = be_in;
                  end else begin
                     state_d = ST_EMPTY;
                  end
               end
            end
            default: begin
               state_d     = ST_EMPTY;
               out_valid_d = 1'b0;
            end
         endcase
      end
   end

   // State and data registers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= ST_EMPTY;
         first_q     <= '0;
         hsext_q     <= 1'b0;
         hbe_q       <= 1'b0;
         a_q         <= '0;
         sext_q      <= 1'b0;
         out_valid_q <= 1'b0;
         terr_q      <= 1'b0;
         cnt_q       <= '0;
      end else begin
         state_q     <= state_d;
         first_q     <= first_d;
         hsext_q     <= hsext_d;
         hbe_q       <= hbe_d;
         a_q         <= a_d;
         sext_q      <= sext_d;
         out_valid_q <= out_valid_d;
         terr_q      <= terr_d;
         cnt_q       <= cnt_d;
      end
   end

   assign out_valid   = out_valid_q;
   assign a           = a_q;
   assign sext        = sext_q;
   assign timeout_err = terr_q;
   assign hw_count    = cnt_q;

endmodule

// File: tb/tb_halfword_assembler.sv
// Scoreboarded bench for halfword_assembler: directed scenarios then random traffic.
// Latency: n/a.
// Backpressure: out_ready randomised; flush cycles hold out_ready low.
module tb_halfword_assembler;

   localparam int TO = 16;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        in_valid = 1'b0;
   logic        in_ready;
   logic [7:0]  in_data = '0;
   logic        in_sext = 1'b0;
   logic        big_endian = 1'b0;
   logic        flush = 1'b0;
   logic        out_valid;
   logic        out_ready = 1'b0;
   logic [15:0] a;
   logic        sext;
   logic        timeout_err;
   logic [15:0] hw_count;

   int total = 0;
   int bad   = 0;
   int terr_seen = 0;
   int cyc_n = 0;

   always #5 clk = ~clk;

   halfword_assembler #(.TIMEOUT(TO)) dut (
      .clk         (clk),
      .rst         (rst),
      .in_valid    (in_valid),
      .in_ready    (in_ready),
      .in_data     (in_data),
      .in_sext     (in_sext),
`ifdef ASSEMBLER_BE_EN
      .big_endian  (big_endian),
`endif
      .flush       (flush),
      .out_valid   (out_valid),
      .out_ready   (out_ready),
      .a           (a),
      .sext        (sext),
      .timeout_err (timeout_err),
      .hw_count    (hw_count)
   );

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at t=%0t", nm, act, exp, $time);
      end
   endtask

   function automatic logic [31:0] ext(input logic [15:0] v, input logic s);
      return s ? {{16{v[15]}}, v} : {16'h0000, v};
   endfunction

   // ---------------- reference model: pairs of bytes, not states ----------------
   logic [16:0] exp_q[$];     // {sext, a} of completed pairs awaiting the consumer
   bit          m_have;       // one byte of a pair is held
   bit          m_full;       // a halfword is being presented
   logic [7:0]  m_first;
   bit          m_sext, m_be;
   int          m_idle;
   logic [15:0] m_cnt = '0;
   bit          m_terr;
   bit          ihs, ohs;

   always @(posedge clk or posedge rst) begin
      if (rst) begin
         m_have = 0; m_full = 0; m_idle = 0; m_cnt = '0; m_terr = 0;
         exp_q.delete();
      end else begin
         cyc_n++;
         ihs = in_valid && !flush && (!m_full || out_ready);
         ohs = m_full && out_ready && !flush;
         m_terr = 0;
         if (flush) begin
            m_have = 0; m_full = 0;
            exp_q.delete();
         end else begin
            if (ohs) begin
               m_full = 0;
               m_cnt  = m_cnt + 16'd1;
            end
            if (ihs) begin
               if (!m_have) begin
                  m_have = 1; m_first = in_data; m_sext = in_sext; m_idle = 0;
`ifdef ASSEMBLER_BE_EN
                  m_be = big_endian;
`else
                  m_be = 0;
`endif
               end else begin
                  exp_q.push_back({m_sext, m_be ? {m_first, in_data} : {in_data, m_first}});
                  m_have = 0; m_full = 1;
               end
            end else if (m_have && TO != 0) begin
               if (m_idle == TO) begin
                  m_have = 0; m_terr = 1;
               end else begin
                  m_idle++;
               end
            end
         end
      end
   end

   // ---------------- monitor ----------------
   bit exp_rdy;
   always @(negedge clk) begin
      exp_rdy = !rst && !flush && (!m_full || out_ready);
      chk("in_ready", {31'd0, in_ready}, {31'd0, exp_rdy});
      chk("out_valid", {31'd0, out_valid}, {31'd0, m_full});
      chk("timeout_err", {31'd0, timeout_err}, {31'd0, m_terr});
      chk("hw_count", {16'd0, hw_count}, {16'd0, m_cnt});
      if (timeout_err === 1'b1) terr_seen++;
      if (out_valid === 1'b1) begin
         if (exp_q.size() == 0) begin
            chk("unexpected_out", 32'd1, 32'd0);
         end else begin
            chk("halfword", {15'd0, sext, a}, {15'd0, exp_q[0]});
            if (out_ready && !flush && !rst) void'(exp_q.pop_front());
         end
      end
   end

   // ---------------- stimulus helpers ----------------
   task automatic cyc();
      @(posedge clk); #1;
   endtask

   task automatic put(input logic [7:0] d, input logic s);
      bit ok = 0;
      in_valid = 1'b1; in_data = d; in_sext = s;
      for (int k = 0; k < 100; k++) begin
         @(negedge clk);
         if (in_ready) begin ok = 1; break; end
      end
      if (!ok) chk("put_wait", 32'd0, 32'd1);
      cyc();
      in_valid = 1'b0;
   endtask

   initial begin : watchdog
      #2000000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int t0;
      // Reset state
      #12;
      chk("rst_in_ready", {31'd0, in_ready}, 32'd0);
      chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
      chk("rst_a", {16'd0, a}, 32'd0);
      chk("rst_sext", {31'd0, sext}, 32'd0);
      chk("rst_terr", {31'd0, timeout_err}, 32'd0);
      chk("rst_cnt", {16'd0, hw_count}, 32'd0);
      cyc(); rst = 1'b0; cyc();

      // Sign-extending pair
      out_ready = 1'b1;
      put(8'h00, 1'b1); put(8'h80, 1'b1);
      chk("t1_a", {16'd0, a}, 32'h8000);
      chk("t1_b", ext(a, sext), 32'hFFFF8000);
      cyc();
      chk("t1_cnt", {16'd0, hw_count}, 32'd1);

      // Held output under backpressure
      out_ready = 1'b0;
      put(8'hFF, 1'b0); put(8'hFF, 1'b0);
      for (int i = 0; i < 5; i++) begin
         chk("t2_hold_a", {16'd0, a}, 32'hFFFF);
         chk("t2_hold_rdy", {31'd0, in_ready}, 32'd0);
         cyc();
      end
      chk("t2_b", ext(a, sext), 32'h0000FFFF);
      out_ready = 1'b1; cyc();
      chk("t2_cnt", {16'd0, hw_count}, 32'd2);

      // Abandoned pair
      terr_seen = 0;
      put(8'h12, 1'b0);
      repeat (20) cyc();
      chk("t3_terr_once", terr_seen, 32'd1);
      put(8'h34, 1'b0); put(8'h56, 1'b0);
      chk("t3_a", {16'd0, a}, 32'h5634);
      cyc();

      // Back-to-back traffic
      t0 = cyc_n;
      for (int i = 1; i <= 8; i++) put(8'(i), 1'b0);
      chk("t4_cycles", cyc_n - t0, 32'd8);
      chk("t4_last_a", {16'd0, a}, 32'h0807);
      cyc();
      chk("t4_cnt", {16'd0, hw_count}, 32'd7);

      // Flush in HALF and in FULL
      out_ready = 1'b0; terr_seen = 0;
      put(8'h11, 1'b0);
      flush = 1'b1; cyc(); flush = 1'b0;
      repeat (20) cyc();
      chk("t5_no_terr", terr_seen, 32'd0);
      put(8'h22, 1'b0); put(8'h33, 1'b0);
      chk("t5_full", {31'd0, out_valid}, 32'd1);
      flush = 1'b1; cyc(); flush = 1'b0;
      chk("t5_flushed", {31'd0, out_valid}, 32'd0);
      chk("t5_cnt", {16'd0, hw_count}, 32'd7);
      out_ready = 1'b1;
      put(8'h44, 1'b1); put(8'h55, 1'b1);
      chk("t5_a", {16'd0, a}, 32'h5544);
      cyc();
      chk("t5_cnt2", {16'd0, hw_count}, 32'd8);

      // Reset mid-pair
      put(8'h77, 1'b0);
      #2 rst = 1'b1; #1;
      chk("t6_valid", {31'd0, out_valid}, 32'd0);
      chk("t6_cnt", {16'd0, hw_count}, 32'd0);
      chk("t6_a", {16'd0, a}, 32'd0);
      chk("t6_rdy", {31'd0, in_ready}, 32'd0);
      cyc(); rst = 1'b0; cyc();

`ifdef ASSEMBLER_BE_EN
      big_endian = 1'b1;
      put(8'h80, 1'b0); put(8'h00, 1'b0);
      chk("t7_be_a", {16'd0, a}, 32'h8000);
      big_endian = 1'b0;
      cyc();
`endif

      // Random traffic in sparse and dense phases
      for (int ph = 0; ph < 6; ph++) begin
         int pv;
         pv = (ph % 2 == 0) ? 85 : 6;
         for (int i = 0; i < 500; i++) begin
            in_valid   = ($urandom_range(0, 99) < pv);
            in_data    = 8'($urandom);
            in_sext    = 1'($urandom);
            big_endian = 1'($urandom);
            flush      = ($urandom_range(0, 99) < 2);
            out_ready  = flush ? 1'b0 : ($urandom_range(0, 99) < 70);
            cyc();
         end
      end
      in_valid = 1'b0; flush = 1'b0; out_ready = 1'b1;
      repeat (5) cyc();
      chk("drain_empty", exp_q.size(), 32'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
